// File: rtl/seq_shifter.sv
// Multi-cycle MIPS shift unit: SLL/SRL/SRA (and variable forms) at up to STEP bits per clock.
// Latency: done pulses ceil(n/STEP)+1 edges after the start edge (1 edge when n==0 or pass-through).
// Backpressure: start is ignored while shifting; the pipeline stalls on busy, result held until next done.
module seq_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [31:0]      shamt,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [4:0] STEP_AMT = 5'(STEP);
    localparam logic [1:0] OP_SLL   = 2'b00;
    localparam logic [1:0] OP_SRL   = 2'b01;
    localparam logic [1:0] OP_PASS  = 2'b10;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [4:0]       rem_q, rem_d;
    logic [4:0]       step_k;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Only the 5-bit shift amount is meaningful; the zero-extension bits are dropped.
    logic unused_shamt_hi;
    assign unused_shamt_hi = ^shamt[31:5];

    // Next-state, working-register and output computation for the shift FSM.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rem_d    = rem_q;
        work_d   = work_q;
        step_k   = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
        // Outputs are decoded from the current state and registered, so they trail the state by one edge.
        busy_d   = (state_q == SHIFT);
        done_d   = (state_q == DONE);
        result_d = (state_q == DONE) ? work_q : result_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    work_d  = data_in;
                    op_d    = op;
                    rem_d   = shamt[4:0];
                    state_d = ((shamt[4:0] == 5'd0) || (op == OP_PASS)) ? DONE : SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                case (op_q)
                    OP_SLL:  work_d = work_q << step_k;
                    OP_SRL:  work_d = work_q >> step_k;
                    // SRA: the sign bit never changes while shifting right, so it replicates the original bit 31.
                    default: work_d = WIDTH'($signed(work_q) >>> step_k);
                endcase
                rem_d = rem_q - step_k;
                if (rem_d == 5'd0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= 2'b00;
            rem_q    <= 5'd0;
            work_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rem_q    <= rem_d;
            work_q   <= work_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
